count_sequencer: RTL

- Control stage directly upstream of the pair of 4-bit up/down counter blocks.
- Conditions two raw push-buttons (sync, debounce, press-edge detect) and generates the shared div_clk tick strobe.
- Sequences the up counter, then the down counter, for ROUNDS passes by issuing single-cycle go/pause pulses.
- Advances on the counters' done_sig rising edges.

---
 rtl/count_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/count_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : count_sequencer
// Purpose  : Button conditioning, shared tick strobe and up/down pass
//            sequencing for a pair of 4-bit counter blocks.
// Revision : 1.0 - initial release
// ============================================================================
module count_sequencer #(
    parameter int DIV_WIDTH       = 24,
    parameter int CLK_DIV         = 6000000,
    parameter int DB_WIDTH        = 17,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int ROUNDS          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_go,
    input  logic       btn_pause,
    input  logic       up_done,
    input  logic       down_done,
    output logic       div_clk,
    output logic       go_up,
    output logic       go_down,
    output logic       pause_up,
    output logic       pause_down,
    output logic       busy,
    output logic       paused,
    output logic [3:0] round
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_RUN_UP   = 2'd1;
    localparam logic [1:0] c_ST_RUN_DOWN = 2'd2;

    localparam logic [DIV_WIDTH-1:0] c_DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [DB_WIDTH-1:0]  c_DB_LAST  = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]           c_ROUNDS   = 5'(ROUNDS);

    // ------------------------------------------------------------------
    // Tick divider: strobe registered out of the terminal count
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic                 r_div_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_div_clk <= 1'b0;
        end else begin
            r_div_clk <= (r_div_cnt == c_DIV_LAST);
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + DIV_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = go, index 1 = pause
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_pause, btn_go};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic                r_sync1;
        logic                r_sync2;
        logic                r_level;
        logic                r_level_d;
        logic [DB_WIDTH-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_d <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_btn_raw[gi];
                r_sync2   <= r_sync1;
                r_level_d <= r_level;
                if (r_sync2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_WIDTH'(1);
                end
            end
        end

        assign w_press[gi] = r_level & ~r_level_d;
    end

    // ------------------------------------------------------------------
    // Done rise detection on registered copies of the counter flags
    // ------------------------------------------------------------------
    logic r_up_q, r_up_q2, r_dn_q, r_dn_q2;
    logic w_up_rise, w_dn_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_q  <= 1'b0;
            r_up_q2 <= 1'b0;
            r_dn_q  <= 1'b0;
            r_dn_q2 <= 1'b0;
        end else begin
            r_up_q  <= up_done;
            r_up_q2 <= r_up_q;
            r_dn_q  <= down_done;
            r_dn_q2 <= r_dn_q;
        end
    end

    assign w_up_rise = r_up_q & ~r_up_q2;
    assign w_dn_rise = r_dn_q & ~r_dn_q2;

    // ------------------------------------------------------------------
    // Sequencer FSM: state/output register, next-state logic, decode
    // ------------------------------------------------------------------
    logic [1:0] r_state, w_state;
    logic       r_go_up, r_go_down, r_pause_up, r_pause_down, r_paused;
    logic       w_go_up, w_go_down, w_pause_up, w_pause_down, w_paused;
    logic [3:0] r_round, w_round;
    logic [4:0] w_round_plus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_go_up      <= 1'b0;
            r_go_down    <= 1'b0;
            r_pause_up   <= 1'b0;
            r_pause_down <= 1'b0;
            r_paused     <= 1'b0;
            r_round      <= 4'd0;
        end else begin
            r_state      <= w_state;
            r_go_up      <= w_go_up;
            r_go_down    <= w_go_down;
            r_pause_up   <= w_pause_up;
            r_pause_down <= w_pause_down;
            r_paused     <= w_paused;
            r_round      <= w_round;
        end
    end

    assign w_round_plus = {1'b0, r_round} + 5'd1;

    always_comb begin
        w_state      = r_state;
        w_go_up      = 1'b0;
        w_go_down    = 1'b0;
        w_pause_up   = 1'b0;
        w_pause_down = 1'b0;
        w_paused     = r_paused;
        w_round      = r_round;
        case (r_state)
            c_ST_IDLE: begin
                if (w_press[0]) begin
                    w_go_up  = 1'b1;
                    w_round  = 4'd0;
                    w_paused = 1'b0;
                    w_state  = c_ST_RUN_UP;
                end
            end
            c_ST_RUN_UP: begin
                // A done rise outranks any button; the counter is idle again
                if (w_up_rise) begin
                    w_go_down = 1'b1;
                    w_paused  = 1'b0;
                    w_state   = c_ST_RUN_DOWN;
                end else if (!r_paused) begin
                    if (w_press[1]) begin
                        w_pause_up = 1'b1;
                        w_paused   = 1'b1;
                    end
                end else if (w_press[0] || w_press[1]) begin
                    w_go_up  = 1'b1;
                    w_paused = 1'b0;
                end
            end
            c_ST_RUN_DOWN: begin
                if (w_dn_rise) begin
                    w_paused = 1'b0;
                    if (w_round_plus <= c_ROUNDS) begin
                        w_round = w_round_plus[3:0];
                    end
                    if (w_round_plus < c_ROUNDS) begin
                        w_go_up = 1'b1;
                        w_state = c_ST_RUN_UP;
                    end else begin
                        w_state = c_ST_IDLE;
                    end
                end else if (!r_paused) begin
                    if (w_press[1]) begin
                        w_pause_down = 1'b1;
                        w_paused     = 1'b1;
                    end
                end else if (w_press[0] || w_press[1]) begin
                    w_go_down = 1'b1;
                    w_paused  = 1'b0;
                end
            end
            default: begin
                w_state  = c_ST_IDLE;
                w_paused = 1'b0;
            end
        endcase
    end

    always_comb begin
        div_clk    = r_div_clk;
        go_up      = r_go_up;
        go_down    = r_go_down;
        pause_up   = r_pause_up;
        pause_down = r_pause_down;
        busy       = (r_state == c_ST_RUN_UP) || (r_state == c_ST_RUN_DOWN);
        paused     = r_paused;
        round      = r_round;
    end

endmodule
`default_nettype wire
